// File: rtl/f1_light_monitor_pkg.sv
// Shared types and constants for the F1 start-light monitor: FSM state encoding,
// the all-off / all-lit patterns and the level-to-thermometer mapping.
package f1_pkg;

   typedef enum logic [2:0] {
      MON_IDLE   = 3'd0,
      MON_BUILD  = 3'd1,
      MON_ARMED  = 3'd2,
      MON_TIMING = 3'd3,
      MON_DONE   = 3'd4,
      MON_FAULT  = 3'd5
   } mon_state_t;

   localparam logic [7:0] LIGHTS_OFF = 8'h00;
   localparam logic [7:0] LIGHTS_ALL = 8'hFF;
   localparam int         NUM_LIGHTS = 8;

   // Levels above 8 clamp to the fully lit bar.
   function automatic logic [7:0] level_to_pattern(input logic [3:0] lvl);
      logic [8:0] ones;
      if (lvl >= 4'd8) begin
         ones = 9'h0FF;
      end else begin
         ones = (9'd1 << lvl) - 9'd1;
      end
      return ones[7:0];
   endfunction

endpackage

// File: rtl/f1_light_monitor_if.sv
// Signal bundle between the light-sequence side (master) and the monitor (slave),
// including a debug view of the monitor FSM state.
interface f1_light_monitor_if
   import f1_pkg::*;
#(
   parameter int CNT_WIDTH = 16
);

   // Inputs to the monitor
   logic [7:0]           lights;
   logic                 trigger;
   logic                 clr;

   // Results. reaction_valid is a sticky qualifier, not a handshake: once high,
   // reaction_time is stable until clr or rst; there is no ready/back-pressure.
   logic [3:0]           level;
   logic                 go;
   logic                 reaction_valid;
   logic [CNT_WIDTH-1:0] reaction_time;
   logic                 timeout;
   logic                 jump_start;
   logic                 seq_error;

   mon_state_t           state;

   modport master (
      output lights, trigger, clr,
      input  level, go, reaction_valid, reaction_time,
      input  timeout, jump_start, seq_error, state
   );

   modport slave (
      input  lights, trigger, clr,
      output level, go, reaction_valid, reaction_time,
      output timeout, jump_start, seq_error, state
   );

endinterface

// File: rtl/f1_light_monitor_thermo_decode.sv
// Combinational thermometer decoder: number of lit lights and whether the
// pattern is a legal contiguous-from-bit-0 thermometer code.
module thermo_decode
   import f1_pkg::*;
(
   input  logic [7:0] lights,
   output logic [3:0] count,
   output logic       legal
);

   always_comb begin
      count = 4'd0;
      legal = 1'b0;
      for (int i = 0; i <= NUM_LIGHTS; i++) begin
         if (lights == level_to_pattern(4'(i))) begin
            count = 4'(i);
            legal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/f1_light_monitor.sv
// Start-light monitor: follows the light bar from 0 to 8 lit, detects lights
// out, times the driver's reaction and flags jump starts, bad sequences and timeouts.
module f1_light_monitor
   import f1_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   f1_light_monitor_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   mon_state_t           state_q, state_d;
   logic [3:0]           level_q, level_d;
   logic                 go_q, go_d;
   logic                 rv_q, rv_d;
   logic [CNT_WIDTH-1:0] rt_q, rt_d;
   logic                 to_q, to_d;
   logic                 js_q, js_d;
   logic                 se_q, se_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [3:0]           dec_count;
   logic                 dec_legal;
   logic [3:0]           level_up;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 is_same;
   logic                 is_next;

   thermo_decode u_decode (
      .lights (bus.lights),
      .count  (dec_count),
      .legal  (dec_legal)
   );

   assign level_up = level_q + 4'd1;
   assign cnt_inc  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   assign is_same  = dec_legal && (dec_count == level_q);
   assign is_next  = dec_legal && (dec_count == level_up);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MON_IDLE;
         level_q <= 4'd0;
         go_q    <= 1'b0;
         rv_q    <= 1'b0;
         rt_q    <= '0;
         to_q    <= 1'b0;
         js_q    <= 1'b0;
         se_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         go_q    <= go_d;
         rv_q    <= rv_d;
         rt_q    <= rt_d;
         to_q    <= to_d;
         js_q    <= js_d;
         se_q    <= se_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      go_d    = 1'b0;
      rv_d    = rv_q;
      rt_d    = rt_q;
      to_d    = to_q;
      js_d    = js_q;
      se_d    = se_q;
      cnt_d   = cnt_q;

      if (bus.clr) begin
         state_d = MON_IDLE;
         level_d = 4'd0;
         rv_d    = 1'b0;
         rt_d    = '0;
         to_d    = 1'b0;
         js_d    = 1'b0;
         se_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            MON_IDLE: begin
               level_d = 4'd0;
               if (bus.lights == LIGHTS_OFF) begin
                  state_d = MON_IDLE;
               end else if (dec_legal && dec_count == 4'd1) begin
                  state_d = MON_BUILD;
                  level_d = 4'd1;
               end else begin
                  state_d = MON_FAULT;
                  se_d    = 1'b1;
               end
            end

            // The button is checked before the lights so a press during the
            // build is always a jump start, whatever the bar shows.
            MON_BUILD: begin
               if (bus.trigger) begin
                  state_d = MON_FAULT;
                  level_d = 4'd0;
                  js_d    = 1'b1;
               end else if (is_same) begin
                  state_d = MON_BUILD;
               end else if (is_next) begin
                  level_d = level_up;
                  if (level_up == 4'd8) begin
                     state_d = MON_ARMED;
                  end
               end else begin
                  state_d = MON_FAULT;
                  level_d = 4'd0;
                  se_d    = 1'b1;
               end
            end

            MON_ARMED: begin
               if (bus.trigger) begin
                  state_d = MON_FAULT;
                  level_d = 4'd0;
                  js_d    = 1'b1;
               end else if (bus.lights == LIGHTS_ALL) begin
                  state_d = MON_ARMED;
               end else if (bus.lights == LIGHTS_OFF) begin
                  state_d = MON_TIMING;
                  level_d = 4'd0;
                  cnt_d   = '0;
                  go_d    = 1'b1;
               end else begin
                  state_d = MON_FAULT;
                  level_d = 4'd0;
                  se_d    = 1'b1;
               end
            end

            // A trigger on the saturating edge wins over the timeout.
            MON_TIMING: begin
               level_d = 4'd0;
               if (bus.trigger) begin
                  state_d = MON_DONE;
                  rt_d    = cnt_inc;
                  rv_d    = 1'b1;
               end else if (cnt_inc == CNT_MAX) begin
                  state_d = MON_DONE;
                  cnt_d   = cnt_inc;
                  rt_d    = CNT_MAX;
                  rv_d    = 1'b1;
                  to_d    = 1'b1;
               end else begin
                  cnt_d   = cnt_inc;
               end
            end

            MON_DONE: begin
               state_d = MON_DONE;
            end

            MON_FAULT: begin
               state_d = MON_FAULT;
               level_d = 4'd0;
            end

            default: begin
               state_d = MON_FAULT;
               level_d = 4'd0;
               se_d    = 1'b1;
            end
         endcase
      end
   end

   assign bus.level          = level_q;
   assign bus.go             = go_q;
   assign bus.reaction_valid = rv_q;
   assign bus.reaction_time  = rt_q;
   assign bus.timeout        = to_q;
   assign bus.jump_start     = js_q;
   assign bus.seq_error      = se_q;
   assign bus.state          = state_q;

endmodule

// File: tb/tb_f1_light_monitor.sv
// Directed bench for f1_light_monitor: the driver pushes hand-computed
// expectations tagged with the edge they belong to; a negedge monitor checks them.
module tb_f1_light_monitor;
   import f1_pkg::*;

   localparam int CW = 4;
   localparam logic [7:0] PAT [0:8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                        8'h1F, 8'h3F, 8'h7F, 8'hFF};

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   // Packed expectation: {state, level, go, valid, time, timeout, jump, seq}
   logic [15:0] exp_q[$];
   int          cyc_q[$];
   string       name_q[$];

   f1_light_monitor_if #(.CNT_WIDTH(CW)) bus ();

   f1_light_monitor #(.CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers / driver ----------------
   function automatic logic [15:0] ex(input mon_state_t st, input logic [3:0] lv,
                                      input logic g, input logic rv,
                                      input logic [3:0] rt, input logic to,
                                      input logic js, input logic se);
      return {st, lv, g, rv, rt, to, js, se};
   endfunction

   function automatic logic [15:0] ex_idle();
      return ex(MON_IDLE, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic push(input logic [15:0] e, input int c, input string nm);
      exp_q.push_back(e);
      cyc_q.push_back(c);
      name_q.push_back(nm);
   endtask

   // Apply inputs for the next edge; if chk, the expectation is for that edge.
   task automatic step(input logic [7:0] l, input logic t, input logic c,
                       input bit chk, input logic [15:0] e, input string nm);
      bus.lights  = l;
      bus.trigger = t;
      bus.clr     = c;
      if (chk) push(e, cyc + 1, nm);
      @(posedge clk);
      #1;
   endtask

   task automatic stepn(input logic [7:0] l, input logic t);
      step(l, t, 1'b0, 1'b0, 16'h0, "");
   endtask

   task automatic do_clr(input string nm);
      step(8'h00, 1'b0, 1'b1, 1'b1, ex_idle(), nm);
   endtask

   // Legal build to ARMED, checking state and level on every edge.
   task automatic build(input bit hold, input string nm);
      for (int lv = 1; lv <= 8; lv++) begin
         for (int h = 0; h <= (hold ? 1 : 0); h++) begin
            step(PAT[lv], 1'b0, 1'b0, 1'b1,
                 ex((lv == 8) ? MON_ARMED : MON_BUILD, 4'(lv),
                    1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), nm);
         end
      end
   endtask

   task automatic lights_out(input string nm);
      step(8'h00, 1'b0, 1'b0, 1'b1,
           ex(MON_TIMING, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), nm);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [15:0] act;
      act = {bus.state, bus.level, bus.go, bus.reaction_valid, bus.reaction_time,
             bus.timeout, bus.jump_start, bus.seq_error};
      while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
         n_cmp++;
         if (cyc_q[0] != cyc) begin
            n_err++;
            $display("FAIL %s: check for edge %0d missed, now at edge %0d",
                     name_q[0], cyc_q[0], cyc);
         end else if (act !== exp_q[0]) begin
            n_err++;
            $display("FAIL %s: got %h want %h (state,level,go,valid,time,to,js,se)",
                     name_q[0], act, exp_q[0]);
         end
         void'(exp_q.pop_front());
         void'(cyc_q.pop_front());
         void'(name_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst         = 1'b1;
      bus.lights  = 8'h00;
      bus.trigger = 1'b0;
      bus.clr     = 1'b0;
      @(posedge clk);
      #1;
      push(ex_idle(), cyc, "reset_state");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(8'h00, 1'b1, 1'b0, 1'b1, ex_idle(), "idle_ignores_trigger");

      // Legal build with holds, reaction of 5 edges; lights ignored in TIMING
      build(1'b1, "build_hold");
      step(8'hFF, 1'b0, 1'b0, 1'b1,
           ex(MON_ARMED, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), "armed_hold");
      lights_out("go_pulse");
      step(8'h01, 1'b0, 1'b0, 1'b1,
           ex(MON_TIMING, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), "go_one_cycle");
      stepn(8'h03, 1'b0);
      stepn(8'h00, 1'b0);
      stepn(8'h00, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b1,
           ex(MON_DONE, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0), "reaction_5");
      step(8'h05, 1'b1, 1'b0, 1'b1,
           ex(MON_DONE, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0), "done_hold");
      do_clr("clr_after_done");

      // Jump start at level 3, then clr
      step(8'h01, 1'b0, 1'b0, 1'b0, 16'h0, "");
      stepn(8'h03, 1'b0);
      step(8'h07, 1'b0, 1'b0, 1'b1,
           ex(MON_BUILD, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), "level_3");
      step(8'h07, 1'b1, 1'b0, 1'b1,
           ex(MON_FAULT, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), "jump_build");
      step(8'h0F, 1'b0, 1'b0, 1'b1,
           ex(MON_FAULT, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), "fault_hold");
      do_clr("clr_after_jump");

      // Skipped level
      stepn(8'h01, 1'b0);
      step(8'h03, 1'b0, 1'b0, 1'b1,
           ex(MON_BUILD, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), "level_2");
      step(8'h0F, 1'b0, 1'b0, 1'b1,
           ex(MON_FAULT, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), "seq_skip");
      do_clr("clr_after_skip");

      // Non-thermometer pattern at level 2
      stepn(8'h01, 1'b0);
      stepn(8'h03, 1'b0);
      step(8'h05, 1'b0, 1'b0, 1'b1,
           ex(MON_FAULT, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), "seq_nonthermo");
      do_clr("clr_after_nonthermo");

      // Illegal first pattern out of IDLE
      step(8'h03, 1'b0, 1'b0, 1'b1,
           ex(MON_FAULT, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), "idle_bad_start");
      do_clr("clr_after_idle_bad");

      // Timeout: 15 edges after go with no trigger
      build(1'b0, "build_to");
      lights_out("go_to");
      for (int i = 1; i <= 13; i++) stepn(8'h00, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b1,
           ex(MON_TIMING, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), "edge_14");
      step(8'h00, 1'b0, 1'b0, 1'b1,
           ex(MON_DONE, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0), "timeout_15");
      step(8'h07, 1'b1, 1'b0, 1'b1,
           ex(MON_DONE, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0), "timeout_hold");
      do_clr("clr_after_timeout");

      // Trigger on the saturating edge is a normal reaction
      build(1'b0, "build_sat");
      lights_out("go_sat");
      for (int i = 1; i <= 14; i++) stepn(8'h00, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b1,
           ex(MON_DONE, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0), "trigger_on_sat");
      do_clr("clr_after_sat");

      // Trigger on the first edge after go
      build(1'b0, "build_r1");
      lights_out("go_r1");
      step(8'h00, 1'b1, 1'b0, 1'b1,
           ex(MON_DONE, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0), "reaction_1");
      do_clr("clr_after_r1");

      // Trigger and lights-out on the same edge in ARMED
      build(1'b0, "build_js");
      step(8'h00, 1'b1, 1'b0, 1'b1,
           ex(MON_FAULT, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), "jump_armed");
      do_clr("clr_after_js");

      // Asynchronous reset with the counter at 7
      build(1'b0, "build_rst");
      lights_out("go_rst");
      for (int i = 1; i <= 7; i++) stepn(8'h00, 1'b0);
      #2;
      rst = 1'b1;
      push(ex_idle(), cyc, "async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(8'h00, 1'b1, 1'b0, 1'b1, ex_idle(), "idle_after_rst");

      // clr beats trigger in TIMING
      build(1'b0, "build_clr");
      lights_out("go_clr");
      stepn(8'h00, 1'b0);
      stepn(8'h00, 1'b0);
      step(8'h00, 1'b1, 1'b1, 1'b1, ex_idle(), "clr_beats_trigger");
      step(8'h00, 1'b0, 1'b0, 1'b1, ex_idle(), "idle_after_clr");

      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d pending checks, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/f1_light_monitor.md
Name: f1_light_monitor

Overview:
- Receiving end of the F1 start-light bar: samples the 8-bit thermometer light pattern driven by the light-sequence FSM and checks that it builds legally from 0 to 8 lights.
- Detects "lights out" after all 8 are lit, then measures driver reaction time in clock cycles until `trigger`.
- Flags jump starts, illegal light sequences and timeouts.
- Sits between the light-sequence FSM output and the display/score logic.

Parameters:
- CNT_WIDTH, 16, width of the reaction-time counter and result; saturates at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lights  input  8  light pattern, sampled every rising edge (legal values 0x00,0x01,0x03,...,0xFF).
- trigger  input  1  driver button, level, synchronous to clk.
- clr  input  1  synchronous clear: return to IDLE and clear all results.
- level  output  4  lights currently tracked as lit, 0..8.
- go  output  1  one-cycle pulse: lights-out detected.
- reaction_valid  output  1  reaction_time holds a result (sticky until clr/rst).
- reaction_time  output  CNT_WIDTH  measured cycles, lights-out to trigger.
- timeout  output  1  counter saturated without trigger (sticky).
- jump_start  output  1  trigger before lights out (sticky).
- seq_error  output  1  illegal or out-of-order pattern (sticky).

Behaviour:
- All outputs are registered.
- Reset state: IDLE. On reset, every output is 0, and the internal counter is 0.
- Reset mid-operation aborts immediately; no partial result is kept.
- States: IDLE, BUILD, ARMED, TIMING, DONE, FAULT.
- clr has priority over all other inputs in every state. It forces IDLE and zeroes all outputs at the next edge.
- IDLE:
  - lights==0x00: stay.
  - lights==0x01: go to BUILD, level=1.
  - Any other value: go to FAULT with seq_error=1.
  - trigger is ignored in IDLE.
- BUILD:
  - trigger=1: go to FAULT with jump_start=1. This is checked before lights.
  - lights equal to the pattern for the current level: stay. Generator hold cycles are allowed.
  - lights equal to the pattern for level+1: level increments. Reaching level 8 goes to ARMED.
  - Any other value (skip, decrease, non-thermometer): go to FAULT with seq_error=1.
- ARMED (level=8):
  - trigger=1: go to FAULT with jump_start=1. This holds even if lights==0x00 on the same edge.
  - lights==0xFF: stay.
  - lights==0x00: go to TIMING, level=0, counter=0, go=1 for exactly the following cycle.
  - Any other value: go to FAULT with seq_error=1.
- TIMING:
  - lights are ignored; the generator may restart its sequence.
  - Each edge without trigger: counter+1.
  - Edge with trigger: reaction_time<=counter+1, reaction_valid=1, go to DONE.
  - A trigger sampled on the first edge after go rises gives reaction_time=1.
  - If counter+1 reaches 2^CNT_WIDTH-1 with no trigger: reaction_time=max, reaction_valid=1, timeout=1, go to DONE.
  - trigger on the saturating edge: treated as a normal trigger (timeout=0).
- DONE and FAULT:
  - Hold all outputs; ignore lights and trigger.
  - Leave only via clr or rst.
- level is 0 in IDLE, FAULT and TIMING, and holds its last value in DONE.

Decomposition:
- Package f1_pkg holds:
  - monitor state enum (mon_state_t);
  - LIGHTS_OFF=8'h00 and LIGHTS_ALL=8'hFF;
  - a function mapping a level 0..8 to its thermometer pattern.
- Sub-module thermo_decode: combinational. Maps 8-bit lights to a 4-bit count plus a legal flag. The FSM uses the count and legal flag to test for "same" and "next" level.

Test Plan:
- Legal build with a 2-cycle hold per level (0x01..0xFF), then 0x00, trigger 5 edges after go rises -> go pulses once; reaction_time=5, reaction_valid=1; timeout, jump_start and seq_error all 0.
- Build to level 3 (0x07), then trigger=1 -> next edge: jump_start=1, state FAULT, reaction_valid=0. Then clr -> all outputs 0, level=0.
- Sequence 0x01,0x03, then 0x0F (skip) -> seq_error=1. A separate run with 0x05 at level 2 -> seq_error=1.
- CNT_WIDTH=4, lights out, no trigger -> after 15 edges reaction_time=15, timeout=1, reaction_valid=1. Later trigger and lights changes leave outputs unchanged.
- ARMED with lights=0x00 and trigger=1 on the same edge -> jump_start=1, go stays 0.
- rst asserted asynchronously mid-TIMING (counter=7) -> all outputs 0 immediately, state IDLE.
- clr=1 and trigger=1 on the same edge in TIMING -> clr wins; state IDLE, reaction_valid=0.
